// File: rtl/execute_pipe.sv
// Purpose : registered execute stage (ALU, branch target, store data, zero flag) holding results in an EX/MEM register.
// Latency : 1 cycle for ALU ops; N cycles for MUL (iterative shift-add, only when EXECUTE_PIPE_MUL_EN is defined).
// Backpr. : in_ready drops while the output register is full and not being drained, during flush/reset, and while a MUL runs.
//
// Ports   : clk, reset (sync, active-high), flush
//           in_valid/in_ready    - upstream handshake for AluSrc, AluControl, PC_E, signImm_E, readData1_E, readData2_E
//           out_valid/out_ready  - downstream handshake for PCBranch_M, aluResult_M, writeData_M, zero_M
// Config  : define EXECUTE_PIPE_MUL_EN to build the iterative multiplier (AluControl 4'b1000) and its MUL_BUSY state;
//           without it 4'b1000 behaves as any other undefined code (result 0, zero_M 1).
module execute_pipe #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         AluSrc,
    input  logic [3:0]   AluControl,
    input  logic [N-1:0] PC_E,
    input  logic [N-1:0] signImm_E,
    input  logic [N-1:0] readData1_E,
    input  logic [N-1:0] readData2_E,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] PCBranch_M,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] writeData_M,
    output logic         zero_M
);

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;

    logic [N-1:0] src_b;
    logic [N-1:0] alu_comb;
    logic [N-1:0] pc_branch;
    logic         out_free;
    logic         accept;
    logic         load_alu;

    assign src_b     = AluSrc ? signImm_E : readData2_E;
    assign pc_branch = PC_E + (signImm_E << 2);
    // The output register can take a new value if it is empty or being drained this cycle.
    assign out_free  = !out_valid | out_ready;
    assign accept    = in_valid & in_ready;

    always_comb begin
        alu_comb = '0;
        case (AluControl)
            ALU_AND:   alu_comb = readData1_E & src_b;
            ALU_OR:    alu_comb = readData1_E | src_b;
            ALU_ADD:   alu_comb = readData1_E + src_b;
            ALU_SUB:   alu_comb = readData1_E + ~src_b + {{(N-1){1'b0}}, 1'b1};
            ALU_PASSB: alu_comb = src_b;
            ALU_NOR:   alu_comb = ~(readData1_E | src_b);
            default:   alu_comb = '0;
        endcase
    end

`ifdef EXECUTE_PIPE_MUL_EN
    localparam logic [3:0] ALU_MUL     = 4'b1000;
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_MUL_BUSY = 1'b1;
    localparam int         CW          = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
    localparam logic [CW-1:0] DONE_STEP = CW'(N);

    logic [0:0]    state;
    logic [CW-1:0] step_cnt;
    logic [N-1:0]  mcand;
    logic [N-1:0]  mplier;
    logic [N-1:0]  acc;
    logic [N-1:0]  acc_next;
    logic [N-1:0]  mul_pcb;
    logic [N-1:0]  mul_wd;
    logic          is_mul;
    logic          mul_last;
    logic          mul_fire;

    assign is_mul   = (AluControl == ALU_MUL);
    assign load_alu = accept & !is_mul;
    assign in_ready = !reset & !flush & (state == ST_IDLE) & out_free;

    // Once all N steps are done (step_cnt == DONE_STEP) the accumulator is frozen,
    // so a finished product can wait here for the output register indefinitely.
    assign acc_next = ((step_cnt != DONE_STEP) && mplier[0]) ? acc + mcand : acc;
    // step_cnt == LAST_STEP: this edge performs the final step; == DONE_STEP: result waiting.
    assign mul_last = (state == ST_MUL_BUSY) && (step_cnt >= LAST_STEP);
    assign mul_fire = mul_last & out_free;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            step_cnt <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            mul_pcb  <= '0;
            mul_wd   <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else if (accept && is_mul) begin
            state    <= ST_MUL_BUSY;
            step_cnt <= '0;
            mcand    <= readData1_E;
            mplier   <= src_b;
            acc      <= '0;
            mul_pcb  <= pc_branch;
            mul_wd   <= readData2_E;
        end else if (state == ST_MUL_BUSY) begin
            if (mul_fire) begin
                state <= ST_IDLE;
            end
            if (step_cnt != DONE_STEP) begin
                acc      <= acc_next;
                mcand    <= mcand << 1;
                mplier   <= mplier >> 1;
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end
`else
    assign load_alu = accept;
    assign in_ready = !reset & !flush & out_free;
`endif

    // EX/MEM output register. Flush only drops the valid bit; data stays stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            PCBranch_M  <= '0;
            aluResult_M <= '0;
            writeData_M <= '0;
            zero_M      <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_alu) begin
            out_valid   <= 1'b1;
            PCBranch_M  <= pc_branch;
            aluResult_M <= alu_comb;
            writeData_M <= readData2_E;
            zero_M      <= (alu_comb == '0);
`ifdef EXECUTE_PIPE_MUL_EN
        end else if (mul_fire) begin
            out_valid   <= 1'b1;
            PCBranch_M  <= mul_pcb;
            aluResult_M <= acc_next;
            writeData_M <= mul_wd;
            zero_M      <= (acc_next == '0);
`endif
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_pipe.sv
module tb_execute_pipe;
    localparam int N = 64;
    localparam logic [N-1:0] ONES = {N{1'b1}};

    logic         clk = 1'b0;
    logic         reset, flush, in_valid, in_ready, AluSrc, out_valid, out_ready, zero_M;
    logic [3:0]   AluControl;
    logic [N-1:0] PC_E, signImm_E, readData1_E, readData2_E;
    logic [N-1:0] PCBranch_M, aluResult_M, writeData_M;

    execute_pipe #(.N(N)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .AluSrc(AluSrc), .AluControl(AluControl),
        .PC_E(PC_E), .signImm_E(signImm_E), .readData1_E(readData1_E), .readData2_E(readData2_E),
        .out_valid(out_valid), .out_ready(out_ready),
        .PCBranch_M(PCBranch_M), .aluResult_M(aluResult_M), .writeData_M(writeData_M), .zero_M(zero_M)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 2 time units after the active edge; outputs are sampled 1 unit later.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [3:0] ctl, input logic src, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] pc, input logic [N-1:0] imm);
        AluControl  = ctl;
        AluSrc      = src;
        readData1_E = a;
        readData2_E = b;
        PC_E        = pc;
        signImm_E   = imm;
        in_valid    = 1'b1;
    endtask

    // Behavioural reference: plain arithmetic on the architectural operands.
    function automatic logic [N-1:0] ref_alu(input logic [3:0] c, input logic [N-1:0] a, input logic [N-1:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return b;
            4'b1100: return ~(a | b);
`ifdef EXECUTE_PIPE_MUL_EN
            4'b1000: return a * b;
`endif
            default: return '0;
        endcase
    endfunction

    typedef struct {
        string        name;
        logic [3:0]   ctl;
        logic         src;
        logic [N-1:0] a, b, pc, imm;
        logic [N-1:0] res, pcb;
        logic         zero;
    } vec_t;

    typedef struct {
        logic [N-1:0] res, pcb, wd;
        logic         zero;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] thr_exp[4];
        int bad;
        logic acc_s, rel_s, hold;
        exp_t e;
        logic [N-1:0] ra, rb, rpc, rimm;
        logic [3:0] rc;
        logic rsrc;

        vecs[0]  = '{"add",       4'b0010, 1'b0, 64'd5, 64'd7, 64'd100, 64'd3, 64'd12, 64'd112, 1'b0};
        vecs[1]  = '{"sub_eq",    4'b0110, 1'b0, 64'd42, 64'd42, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1};
        vecs[2]  = '{"sub_wrap",  4'b0110, 1'b0, 64'd0, 64'd1, 64'd0, 64'd1, ONES, 64'd4, 1'b0};
        vecs[3]  = '{"and",       4'b0000, 1'b0, 64'hF0F0, 64'hFF00, 64'd8, 64'd2, 64'hF000, 64'd16, 1'b0};
        vecs[4]  = '{"or",        4'b0001, 1'b0, 64'hF0, 64'h0F, 64'd0, 64'd0, 64'hFF, 64'd0, 1'b0};
        vecs[5]  = '{"passb_imm", 4'b0111, 1'b1, 64'd123, 64'd55, 64'h40, 64'hFFFF_FFFF_FFFF_FFFC,
                     64'hFFFF_FFFF_FFFF_FFFC, 64'h30, 1'b0};
        vecs[6]  = '{"nor_zero",  4'b1100, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, ONES, 64'd0, 1'b0};
        vecs[7]  = '{"undef",     4'b0011, 1'b0, 64'd9, 64'd9, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1};
        vecs[8]  = '{"pcb_wrap",  4'b0010, 1'b0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd8, 64'd0, 64'h10, 1'b1};
        vecs[9]  = '{"add_wrap",  4'b0010, 1'b0, ONES, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1};
        vecs[10] = '{"sub_imm",   4'b0110, 1'b1, 64'd10, 64'd99, 64'd0, 64'd3, 64'd7, 64'd12, 1'b0};
        vecs[11] = '{"nor",       4'b1100, 1'b0, 64'hF0, 64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FF0F, 64'd0, 1'b0};

        // ---- reset state (an op is offered but must not be taken) ----
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(4'b0010, 1'b0, 64'd1, 64'd2, 64'd4, 64'd1);
        tick; tick;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu", aluResult_M, 0);
        chk("rst_pcb", PCBranch_M, 0);
        chk("rst_wd", writeData_M, 0);
        chk("rst_zero", zero_M, 0);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        tick;

        // ---- table-driven single operations ----
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].ctl, vecs[i].src, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].imm);
            #1;
            chk({vecs[i].name, "_in_ready"}, in_ready, 1);
            tick;
            in_valid = 1'b0;
            #1;
            chk({vecs[i].name, "_valid"}, out_valid, 1);
            chk({vecs[i].name, "_res"}, aluResult_M, vecs[i].res);
            chk({vecs[i].name, "_pcb"}, PCBranch_M, vecs[i].pcb);
            chk({vecs[i].name, "_wd"}, writeData_M, vecs[i].b);
            chk({vecs[i].name, "_zero"}, zero_M, vecs[i].zero);
            tick;
            #1;
            chk({vecs[i].name, "_released"}, out_valid, 0);
        end

        // ---- backpressure: ADD held for 3 cycles, queued OR loads on release ----
        out_ready = 1'b0;
        drive(4'b0010, 1'b0, 64'd5, 64'd7, 64'd100, 64'd3);
        tick;
        drive(4'b0001, 1'b0, 64'hF0, 64'h0F, 64'd0, 64'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_res_stable", aluResult_M, 64'd12);
            chk("bp_pcb_stable", PCBranch_M, 64'd112);
            tick;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
        #1;
        chk("bp_or_valid", out_valid, 1);
        chk("bp_or_res", aluResult_M, 64'hFF);
        tick;

        // ---- throughput: 4 back-to-back ops ----
        thr_exp[0] = 64'd3; thr_exp[1] = 64'd7; thr_exp[2] = 64'h0F; thr_exp[3] = 64'd100;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive(4'b0010, 1'b0, 64'd1, 64'd2, 64'd0, 64'd0);
                1: drive(4'b0110, 1'b0, 64'd10, 64'd3, 64'd0, 64'd0);
                2: drive(4'b0000, 1'b0, 64'hFF, 64'h0F, 64'd0, 64'd0);
                default: drive(4'b0111, 1'b1, 64'd1, 64'd2, 64'd0, 64'd100);
            endcase
            #1;
            chk("thr_in_ready", in_ready, 1);
            tick;
            chk("thr_valid", out_valid, 1);
            chk("thr_res", aluResult_M, thr_exp[i]);
        end
        in_valid = 1'b0;
        tick;

        // ---- multiply ----
        drive(4'b1000, 1'b0, 64'd6, 64'd7, 64'd0, 64'd1);
        #1;
        chk("mul_in_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
`ifdef EXECUTE_PIPE_MUL_EN
        bad = 0;
        for (int i = 0; i < N; i++) begin
            #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            tick;
        end
        chk("mul_busy_stall_cycles", bad, 0);
        #1;
        chk("mul_valid", out_valid, 1);
        chk("mul_res", aluResult_M, 64'd42);
        chk("mul_zero", zero_M, 0);
        chk("mul_pcb", PCBranch_M, 64'd4);
        chk("mul_wd", writeData_M, 64'd7);
        chk("mul_done_in_ready", in_ready, 1);
`else
        #1;
        chk("mul_undef_valid", out_valid, 1);
        chk("mul_undef_res", aluResult_M, 0);
        chk("mul_undef_zero", zero_M, 1);
`endif
        tick;

        // ---- flush of a held result; an op offered during flush is refused ----
        out_ready = 1'b0;
        drive(4'b0010, 1'b0, 64'd1, 64'd1, 64'd0, 64'd0);
        tick;
        in_valid = 1'b0;
        #1;
        chk("fl_pre_res", aluResult_M, 64'd2);
        out_ready = 1'b1;
        flush = 1'b1;
        drive(4'b0010, 1'b0, 64'd3, 64'd3, 64'd0, 64'd0);
        #1;
        chk("fl_in_ready", in_ready, 0);
        tick;
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("fl_valid", out_valid, 0);
        chk("fl_stale_res", aluResult_M, 64'd2);
        chk("fl_in_ready_back", in_ready, 1);

`ifdef EXECUTE_PIPE_MUL_EN
        // ---- flush at multiply step 10 ----
        drive(4'b1000, 1'b0, 64'd6, 64'd7, 64'd0, 64'd0);
        tick;
        in_valid = 1'b0;
        repeat (9) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        #1;
        chk("mfl_in_ready", in_ready, 1);
        bad = 0;
        for (int i = 0; i < N + 5; i++) begin
            #1;
            if (out_valid !== 1'b0) bad++;
            tick;
        end
        chk("mfl_no_valid_cycles", bad, 0);
`endif

        // ---- reset mid-operation clears the outputs ----
        out_ready = 1'b0;
        drive(4'b0010, 1'b0, 64'd5, 64'd7, 64'd100, 64'd3);
        tick;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
`ifdef EXECUTE_PIPE_MUL_EN
        drive(4'b1000, 1'b0, 64'd6, 64'd7, 64'd0, 64'd0);
        tick;
        in_valid = 1'b0;
        repeat (19) tick;
`endif
        reset = 1'b1;
        tick;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_res", aluResult_M, 0);
        chk("mrst_pcb", PCBranch_M, 0);
        chk("mrst_wd", writeData_M, 0);
        chk("mrst_in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("mrst_first_accept", in_ready, 1);
        tick;
`ifdef EXECUTE_PIPE_MUL_EN
        repeat (N + 2) begin
            #1;
            if (out_valid !== 1'b0) bad++;
            tick;
        end
        chk("mrst_mul_aborted", out_valid, 0);
`endif

        // ---- randomized traffic against the scoreboard ----
        hold = 1'b0;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!hold) begin
                case ($urandom_range(0, 19))
                    0, 1, 2:  rc = 4'b0010;
                    3, 4, 5:  rc = 4'b0110;
                    6, 7:     rc = 4'b0000;
                    8, 9:     rc = 4'b0001;
                    10, 11:   rc = 4'b0111;
                    12, 13:   rc = 4'b1100;
                    14:       rc = 4'b1000;
                    15:       rc = 4'b0101;
                    default:  rc = 4'b0010;
                endcase
                ra   = {$urandom, $urandom};
                rb   = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
                rpc  = {$urandom, $urandom};
                rimm = ($urandom_range(0, 1) == 0) ? N'($urandom_range(0, 255)) : {$urandom, $urandom};
                rsrc = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) != 0) drive(rc, rsrc, ra, rb, rpc, rimm);
                else in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc_s = in_valid & in_ready;
            rel_s = out_valid & out_ready;
            if (out_valid && sb.size() == 0) chk("rnd_spurious_valid", out_valid, 0);
            if (rel_s && sb.size() > 0) begin
                e = sb.pop_front();
                chk("rnd_res", aluResult_M, e.res);
                chk("rnd_pcb", PCBranch_M, e.pcb);
                chk("rnd_wd", writeData_M, e.wd);
                chk("rnd_zero", zero_M, e.zero);
            end
            if (acc_s) begin
                e.res  = ref_alu(AluControl, readData1_E, AluSrc ? signImm_E : readData2_E);
                e.pcb  = PC_E + signImm_E * 4;
                e.wd   = readData2_E;
                e.zero = (e.res == 0);
                sb.push_back(e);
            end
            hold = in_valid & !acc_s;
            tick;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && sb.size() > 0; cyc++) begin
            #1;
            if (out_valid) begin
                e = sb.pop_front();
                chk("drain_res", aluResult_M, e.res);
                chk("drain_zero", zero_M, e.zero);
            end
            tick;
        end
        chk("drain_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
